game_sequencer: RTL and testbench

//   Parametrised session sequencer for N minigames. It latches the difficulty and game

---
 rtl/game_sequencer_if.sv | 39 +++
 rtl/game_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_game_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Game-side bus between the session sequencer and the attached minigame cores.
// Every per-game field is packed with game i at [i*W +: W].
//   game_estado     game -> sequencer  state code of each game
//   game_jogada     game -> sequencer  move count of each game
//   game_pontuacao  game -> sequencer  score of each game
//   game_pronto     game -> sequencer  game i has finished its session
//   jogar           sequencer -> game  one-cycle one-hot start pulse
interface game_sequencer_if #(
  parameter int unsigned N_GAMES = 4,
  parameter int unsigned EST_W   = 4,
  parameter int unsigned JOG_W   = 7,
  parameter int unsigned PTS_W   = 3
);

  logic [N_GAMES*EST_W-1:0] game_estado;
  logic [N_GAMES*JOG_W-1:0] game_jogada;
  logic [N_GAMES*PTS_W-1:0] game_pontuacao;
  logic [N_GAMES-1:0]       game_pronto;
  logic [N_GAMES-1:0]       jogar;

  // Sequencer side
  modport master (
    input  game_estado,
    input  game_jogada,
    input  game_pontuacao,
    input  game_pronto,
    output jogar
  );

  // Game-core side
  modport slave (
    output game_estado,
    output game_jogada,
    output game_pontuacao,
    output game_pronto,
    input  jogar
  );

endinterface

// File: rtl/game_sequencer.sv
// Session sequencer for N_GAMES minigames. Latches difficulty and game selection,
// waits a fixed pre-game interval, pulses jogar for the selected game, supervises it
// with an optional timeout and muxes its estado/jogada/score buses to the board.
// Keeps a best-score register per game.
// Ports:
//   clock, reset_in          clock (rising edge), async active-low reset
//   iniciar                  start request
//   dificuldade_in           difficulty switch
//   minigame_in              game select switch
//   games                    game-side bus (master modport)
//   dificuldade, minigame    latched difficulty / selection
//   estado_out               displayed state code
//   jogada_out               jogadas of the latched game (combinational)
//   pontuacao_out            score captured at end of last session
//   recorde_out              best score of the latched game
//   fsm_state                current sequencer state
//   timeout                  last session ended by timeout
module game_sequencer #(
  parameter int unsigned N_GAMES         = 4,
  parameter int unsigned SEL_W           = 2,
  parameter int unsigned EST_W           = 4,
  parameter int unsigned JOG_W           = 7,
  parameter int unsigned PTS_W           = 3,
  parameter int unsigned INTERVAL_CYCLES = 2000,
  parameter int unsigned TIMEOUT_CYCLES  = 0,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                 clock,
  input  logic                 reset_in,
  input  logic                 iniciar,
  input  logic                 dificuldade_in,
  input  logic [SEL_W-1:0]     minigame_in,
  game_sequencer_if.master     games,
  output logic                 dificuldade,
  output logic [SEL_W-1:0]     minigame,
  output logic [EST_W-1:0]     estado_out,
  output logic [JOG_W-1:0]     jogada_out,
  output logic [PTS_W-1:0]     pontuacao_out,
  output logic [PTS_W-1:0]     recorde_out,
  output logic [2:0]           fsm_state,
  output logic                 timeout
);

  localparam logic [2:0] S_INICIAL    = 3'd0;
  localparam logic [2:0] S_PREPARACAO = 3'd1;
  localparam logic [2:0] S_EXECUCAO   = 3'd2;
  localparam logic [2:0] S_FIM        = 3'd3;
  localparam logic [2:0] S_INTERVALO  = 3'd4;
  localparam logic [2:0] S_START      = 3'd5;

  localparam logic [CNT_W-1:0] IV_LAST = CNT_W'(INTERVAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);

  logic [2:0]       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] minigame_q;
  logic             dificuldade_q;
  logic [PTS_W-1:0] pontuacao_q;
  logic             timeout_q;
  logic [PTS_W-1:0] recorde_q [N_GAMES];

  logic             sel_in_range_c;
  logic             end_ok_c;
  logic             end_to_c;
  logic             pronto_sel_c;
  logic [EST_W-1:0] est_sel_c;
  logic [JOG_W-1:0] jog_sel_c;
  logic [PTS_W-1:0] pts_sel_c;
  logic [PTS_W-1:0] rec_sel_c;

  // Per-game mux on the latched selection; an out-of-range selection reads as zero
  always_comb begin
    est_sel_c    = '0;
    jog_sel_c    = '0;
    pts_sel_c    = '0;
    rec_sel_c    = '0;
    pronto_sel_c = 1'b0;
    for (int i = 0; i < N_GAMES; i++) begin
      if (minigame_q == SEL_W'(i)) begin
        est_sel_c    = games.game_estado[i*EST_W +: EST_W];
        jog_sel_c    = games.game_jogada[i*JOG_W +: JOG_W];
        pts_sel_c    = games.game_pontuacao[i*PTS_W +: PTS_W];
        rec_sel_c    = recorde_q[i];
        pronto_sel_c = games.game_pronto[i];
      end
    end
  end

  // Selection switch points at an attached game (extra bit keeps the compare meaningful)
  always_comb begin
    sel_in_range_c = ({1'b0, minigame_in} < (SEL_W+1)'(N_GAMES));
  end

  // Next-state logic; end_ok_c / end_to_c flag the two kinds of FIM entry
  always_comb begin
    state_nxt = state_q;
    end_ok_c  = 1'b0;
    end_to_c  = 1'b0;
    case (state_q)
      S_INICIAL: begin
        if (iniciar) state_nxt = S_PREPARACAO;
      end
      S_PREPARACAO: begin
        if (sel_in_range_c) state_nxt = S_INTERVALO;
      end
      S_INTERVALO: begin
        if (cnt_q == IV_LAST) state_nxt = S_START;
      end
      S_START: begin
        state_nxt = S_EXECUCAO;
      end
      S_EXECUCAO: begin
        // A finishing game beats a coincident timeout
        if (pronto_sel_c) begin
          state_nxt = S_FIM;
          end_ok_c  = 1'b1;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_nxt = S_FIM;
          end_to_c  = 1'b1;
        end
      end
      S_FIM: begin
        if (iniciar) state_nxt = S_PREPARACAO;
      end
      default: begin
        state_nxt = S_INICIAL;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) state_q <= S_INICIAL;
    else           state_q <= state_nxt;
  end

  // Interval/timeout counter: zero on every state change, counts while waiting
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q <= '0;
    end else if (state_nxt != state_q) begin
      cnt_q <= '0;
    end else if ((state_q == S_INTERVALO) || (state_q == S_EXECUCAO)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Switches are tracked until the session leaves PREPARACAO
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      minigame_q    <= '0;
      dificuldade_q <= 1'b0;
    end else if ((state_q == S_INICIAL) || (state_q == S_PREPARACAO)) begin
      minigame_q    <= minigame_in;
      dificuldade_q <= dificuldade_in;
    end
  end

  // Session result captured on FIM entry
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      pontuacao_q <= '0;
      timeout_q   <= 1'b0;
    end else if (end_ok_c) begin
      pontuacao_q <= pts_sel_c;
      timeout_q   <= 1'b0;
    end else if (end_to_c) begin
      pontuacao_q <= '0;
      timeout_q   <= 1'b1;
    end
  end

  // Best score per game, updated only on a strictly higher normal finish
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < N_GAMES; i++) recorde_q[i] <= '0;
    end else if (end_ok_c) begin
      for (int i = 0; i < N_GAMES; i++) begin
        if ((minigame_q == SEL_W'(i)) && (pts_sel_c > recorde_q[i])) begin
          recorde_q[i] <= pts_sel_c;
        end
      end
    end
  end

  // Start pulse decoded from the state register
  always_comb begin
    games.jogar = '0;
    if (state_q == S_START) begin
      for (int i = 0; i < N_GAMES; i++) begin
        if (minigame_q == SEL_W'(i)) games.jogar[i] = 1'b1;
      end
    end
  end

  // Display code: sequencer state before the game runs, game state afterwards
  always_comb begin
    estado_out = est_sel_c;
    if (state_q == S_INTERVALO) begin
      estado_out = EST_W'(1);
    end else if ((state_q == S_INICIAL) || (state_q == S_PREPARACAO)) begin
      estado_out = EST_W'(state_q);
    end
  end

  assign dificuldade   = dificuldade_q;
  assign minigame      = minigame_q;
  assign jogada_out    = jog_sel_c;
  assign pontuacao_out = pontuacao_q;
  assign recorde_out   = rec_sel_c;
  assign fsm_state     = state_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a 4-game instance (interval 8, timeout 16) driven
// from a vector table, and a 3-game instance (timeout disabled) for the range check.
module tb_game_sequencer;

  logic clock;
  logic reset_in;

  // 4-game instance
  logic       ini4, dif4;
  logic [1:0] mg4;
  logic       dif4_o, to4;
  logic [1:0] mg4_o;
  logic [3:0] est4;
  logic [6:0] jog4;
  logic [2:0] pont4, rec4, st4;

  // 3-game instance
  logic       ini3, dif3;
  logic [1:0] mg3;
  logic       dif3_o, to3;
  logic [1:0] mg3_o;
  logic [3:0] est3;
  logic [6:0] jog3;
  logic [2:0] pont3, rec3, st3;

  game_sequencer_if #(.N_GAMES(4), .EST_W(4), .JOG_W(7), .PTS_W(3)) gif4 ();
  game_sequencer_if #(.N_GAMES(3), .EST_W(4), .JOG_W(7), .PTS_W(3)) gif3 ();

  game_sequencer #(
    .N_GAMES(4), .SEL_W(2), .EST_W(4), .JOG_W(7), .PTS_W(3),
    .INTERVAL_CYCLES(8), .TIMEOUT_CYCLES(16), .CNT_W(32)
  ) dut4 (
    .clock(clock), .reset_in(reset_in), .iniciar(ini4), .dificuldade_in(dif4),
    .minigame_in(mg4), .games(gif4.master), .dificuldade(dif4_o), .minigame(mg4_o),
    .estado_out(est4), .jogada_out(jog4), .pontuacao_out(pont4), .recorde_out(rec4),
    .fsm_state(st4), .timeout(to4)
  );

  game_sequencer #(
    .N_GAMES(3), .SEL_W(2), .EST_W(4), .JOG_W(7), .PTS_W(3),
    .INTERVAL_CYCLES(8), .TIMEOUT_CYCLES(0), .CNT_W(32)
  ) dut3 (
    .clock(clock), .reset_in(reset_in), .iniciar(ini3), .dificuldade_in(dif3),
    .minigame_in(mg3), .games(gif3.master), .dificuldade(dif3_o), .minigame(mg3_o),
    .estado_out(est3), .jogada_out(jog3), .pontuacao_out(pont3), .recorde_out(rec3),
    .fsm_state(st3), .timeout(to3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       ini;
    logic       dif;
    logic [1:0] mg;
    logic [3:0] pronto;
    logic [2:0] score;
    int         n;
    logic [2:0] e_state;
    logic [3:0] e_jogar;
    logic [1:0] e_mg;
    logic       e_dif;
    logic [2:0] e_pont;
    logic [2:0] e_rec;
    logic       e_to;
    logic [3:0] e_est;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    //           ini dif mg pronto   sc  n   st jogar    mg dif pont rec to est
    tbl[0]  = '{1'b1,1'b1,2'd1+2'd1,4'b0000,3'd0, 1, 3'd1,4'b0000,2'd2,1'b1,3'd0,3'd0,1'b0,4'd1};
    tbl[1]  = '{1'b0,1'b1,2'd2,4'b0000,3'd0, 1, 3'd4,4'b0000,2'd2,1'b1,3'd0,3'd0,1'b0,4'd1};
    tbl[2]  = '{1'b1,1'b1,2'd2,4'b0000,3'd0, 7, 3'd4,4'b0000,2'd2,1'b1,3'd0,3'd0,1'b0,4'd1};
    tbl[3]  = '{1'b1,1'b1,2'd2,4'b0000,3'd0, 1, 3'd5,4'b0100,2'd2,1'b1,3'd0,3'd0,1'b0,4'd10};
    tbl[4]  = '{1'b0,1'b1,2'd2,4'b0000,3'd0, 1, 3'd2,4'b0000,2'd2,1'b1,3'd0,3'd0,1'b0,4'd10};
    tbl[5]  = '{1'b1,1'b1,2'd2,4'b0001,3'd0, 3, 3'd2,4'b0000,2'd2,1'b1,3'd0,3'd0,1'b0,4'd10};
    tbl[6]  = '{1'b0,1'b1,2'd2,4'b0100,3'd6, 1, 3'd3,4'b0000,2'd2,1'b1,3'd6,3'd6,1'b0,4'd10};
    tbl[7]  = '{1'b1,1'b0,2'd1,4'b0000,3'd6, 1, 3'd1,4'b0000,2'd2,1'b1,3'd6,3'd6,1'b0,4'd1};
    tbl[8]  = '{1'b0,1'b0,2'd1,4'b0000,3'd6, 1, 3'd4,4'b0000,2'd1,1'b0,3'd6,3'd0,1'b0,4'd1};
    tbl[9]  = '{1'b0,1'b0,2'd1,4'b0000,3'd6, 8, 3'd5,4'b0010,2'd1,1'b0,3'd6,3'd0,1'b0,4'd9};
    tbl[10] = '{1'b0,1'b0,2'd1,4'b0000,3'd6, 1, 3'd2,4'b0000,2'd1,1'b0,3'd6,3'd0,1'b0,4'd9};
    tbl[11] = '{1'b0,1'b0,2'd1,4'b0010,3'd5, 1, 3'd3,4'b0000,2'd1,1'b0,3'd5,3'd5,1'b0,4'd9};
    tbl[12] = '{1'b1,1'b0,2'd1,4'b0000,3'd5, 1, 3'd1,4'b0000,2'd1,1'b0,3'd5,3'd5,1'b0,4'd1};
    tbl[13] = '{1'b0,1'b0,2'd1,4'b0000,3'd5, 1, 3'd4,4'b0000,2'd1,1'b0,3'd5,3'd5,1'b0,4'd1};
    tbl[14] = '{1'b0,1'b0,2'd1,4'b0000,3'd5, 9, 3'd2,4'b0000,2'd1,1'b0,3'd5,3'd5,1'b0,4'd9};
    tbl[15] = '{1'b0,1'b0,2'd1,4'b0010,3'd3, 1, 3'd3,4'b0000,2'd1,1'b0,3'd3,3'd5,1'b0,4'd9};
    tbl[16] = '{1'b1,1'b0,2'd1,4'b0000,3'd3, 1, 3'd1,4'b0000,2'd1,1'b0,3'd3,3'd5,1'b0,4'd1};
    tbl[17] = '{1'b0,1'b0,2'd1,4'b0000,3'd3, 1, 3'd4,4'b0000,2'd1,1'b0,3'd3,3'd5,1'b0,4'd1};
    tbl[18] = '{1'b0,1'b0,2'd1,4'b0000,3'd3, 9, 3'd2,4'b0000,2'd1,1'b0,3'd3,3'd5,1'b0,4'd9};
    tbl[19] = '{1'b0,1'b0,2'd1,4'b0000,3'd3,15, 3'd2,4'b0000,2'd1,1'b0,3'd3,3'd5,1'b0,4'd9};
    tbl[20] = '{1'b0,1'b0,2'd1,4'b0000,3'd3, 1, 3'd3,4'b0000,2'd1,1'b0,3'd0,3'd5,1'b1,4'd9};
    tbl[21] = '{1'b1,1'b0,2'd1,4'b0000,3'd3, 1, 3'd1,4'b0000,2'd1,1'b0,3'd0,3'd5,1'b1,4'd1};
    tbl[22] = '{1'b0,1'b0,2'd1,4'b0000,3'd3, 1, 3'd4,4'b0000,2'd1,1'b0,3'd0,3'd5,1'b1,4'd1};
    tbl[23] = '{1'b0,1'b0,2'd1,4'b0000,3'd3, 9, 3'd2,4'b0000,2'd1,1'b0,3'd0,3'd5,1'b1,4'd9};
    tbl[24] = '{1'b0,1'b0,2'd1,4'b0000,3'd3,15, 3'd2,4'b0000,2'd1,1'b0,3'd0,3'd5,1'b1,4'd9};
    tbl[25] = '{1'b0,1'b0,2'd1,4'b0010,3'd4, 1, 3'd3,4'b0000,2'd1,1'b0,3'd4,3'd5,1'b0,4'd9};
    tbl[26] = '{1'b0,1'b0,2'd1,4'b0000,3'd4, 5, 3'd3,4'b0000,2'd1,1'b0,3'd4,3'd5,1'b0,4'd9};

    // Game buses: game i shows estado 8+i (5+i on the 3-game side) and jogadas 10*i+1
    gif4.game_estado    = {4'd11, 4'd10, 4'd9, 4'd8};
    gif4.game_jogada    = {7'd31, 7'd21, 7'd11, 7'd1};
    gif4.game_pontuacao = '0;
    gif4.game_pronto    = '0;
    gif3.game_estado    = {4'd7, 4'd6, 4'd5};
    gif3.game_jogada    = {7'd3, 7'd2, 7'd1};
    gif3.game_pontuacao = {3{3'd7}};
    gif3.game_pronto    = '0;
    ini4 = 1'b0; dif4 = 1'b0; mg4 = 2'd0;
    ini3 = 1'b0; dif3 = 1'b0; mg3 = 2'd0;

    // Reset state
    reset_in = 1'b0;
    tick(2);
    chk("rst_state", 0, 32'(st4), 32'd0);
    chk("rst_jogar", 0, 32'(gif4.jogar), 32'd0);
    chk("rst_pont", 0, 32'(pont4), 32'd0);
    chk("rst_rec", 0, 32'(rec4), 32'd0);
    chk("rst_to", 0, 32'(to4), 32'd0);
    chk("rst_est", 0, 32'(est4), 32'd0);
    chk("rst_mg", 0, 32'(mg4_o), 32'd0);
    chk("rst_dif", 0, 32'(dif4_o), 32'd0);
    reset_in = 1'b1;

    // Table: inputs held for n edges, outputs checked #1 after the last edge
    for (int k = 0; k < NV; k++) begin
      ini4 = tbl[k].ini;
      dif4 = tbl[k].dif;
      mg4  = tbl[k].mg;
      gif4.game_pronto    = tbl[k].pronto;
      gif4.game_pontuacao = {4{tbl[k].score}};
      tick(tbl[k].n);
      chk("state", k, 32'(st4), 32'(tbl[k].e_state));
      chk("jogar", k, 32'(gif4.jogar), 32'(tbl[k].e_jogar));
      chk("minigame", k, 32'(mg4_o), 32'(tbl[k].e_mg));
      chk("dificuldade", k, 32'(dif4_o), 32'(tbl[k].e_dif));
      chk("pontuacao", k, 32'(pont4), 32'(tbl[k].e_pont));
      chk("recorde", k, 32'(rec4), 32'(tbl[k].e_rec));
      chk("timeout", k, 32'(to4), 32'(tbl[k].e_to));
      chk("estado", k, 32'(est4), 32'(tbl[k].e_est));
      chk("jogada", k, 32'(jog4), 10 * 32'(tbl[k].e_mg) + 1);
    end
    ini4 = 1'b0;
    gif4.game_pronto = '0;

    // Out-of-range selection holds PREPARACAO on the 3-game instance
    ini3 = 1'b1; mg3 = 2'd3; dif3 = 1'b1;
    tick(1);
    chk("d3_prep", 0, 32'(st3), 32'd1);
    ini3 = 1'b0;
    tick(3);
    chk("d3_hold", 0, 32'(st3), 32'd1);
    chk("d3_mg_hold", 0, 32'(mg3_o), 32'd3);
    mg3 = 2'd1;
    tick(1);
    chk("d3_intervalo", 0, 32'(st3), 32'd4);
    chk("d3_mg", 0, 32'(mg3_o), 32'd1);
    chk("d3_dif", 0, 32'(dif3_o), 32'd1);
    tick(8);
    chk("d3_start", 0, 32'(st3), 32'd5);
    chk("d3_jogar", 0, 32'(gif3.jogar), 32'b010);
    chk("d3_est", 0, 32'(est3), 32'd6);
    tick(1);
    chk("d3_exec", 0, 32'(st3), 32'd2);
    tick(40);
    chk("d3_no_timeout", 0, 32'(st3), 32'd2);
    gif3.game_pronto = 3'b010;
    tick(1);
    gif3.game_pronto = '0;
    chk("d3_fim", 0, 32'(st3), 32'd3);
    chk("d3_pont", 0, 32'(pont3), 32'd7);
    chk("d3_rec", 0, 32'(rec3), 32'd7);
    chk("d3_to", 0, 32'(to3), 32'd0);

    // Reset in the middle of a game 2 session on the 4-game instance
    ini4 = 1'b1;
    tick(1);
    chk("r_prep", 0, 32'(st4), 32'd1);
    ini4 = 1'b0; mg4 = 2'd2;
    tick(1);
    tick(9);
    chk("r_exec", 0, 32'(st4), 32'd2);
    chk("r_rec_before", 0, 32'(rec4), 32'd6);
    #3;
    reset_in = 1'b0;
    #1;
    chk("r_state", 0, 32'(st4), 32'd0);
    chk("r_pont", 0, 32'(pont4), 32'd0);
    chk("r_jogar", 0, 32'(gif4.jogar), 32'd0);
    chk("r_mg", 0, 32'(mg4_o), 32'd0);
    chk("r_est", 0, 32'(est4), 32'd0);
    chk("r_d3_state", 0, 32'(st3), 32'd0);
    chk("r_d3_pont", 0, 32'(pont3), 32'd0);
    #2;
    reset_in = 1'b1;
    tick(1);
    chk("r_state_after", 0, 32'(st4), 32'd0);
    chk("r_mg_after", 0, 32'(mg4_o), 32'd2);
    chk("r_rec2_cleared", 0, 32'(rec4), 32'd0);
    mg4 = 2'd1;
    tick(1);
    chk("r_rec1_cleared", 0, 32'(rec4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
